// File: rtl/uart_pkg.sv
// Shared UART definitions: line FSM states, frame width and default rates.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS     = 8;
  localparam int unsigned DEF_CLK_FREQ  = 50_000_000;
  localparam int unsigned DEF_BAUD_RATE = 9600;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-in / serial-out signal bundle of the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] in_data;
  logic                 in_en;
  logic                 in_ready;
  logic                 out_data;
  logic                 out_done;

  modport master (
    output in_data, in_en,
    input  in_ready, out_data, out_done
  );

  modport slave (
    input  in_data, in_en,
    output in_ready, out_data, out_done
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: tick_o marks the last clock of each bit, pre_tick_o the clock before.
module uart_baud_gen #(
  parameter int unsigned BIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o,
  output logic pre_tick_o
);

  localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  generate
    if (BIT_CYCLES < 2) begin : g_bad_rate
      $error("uart_baud_gen: BIT_CYCLES must be at least 2");
    end
  endgenerate

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o     = (cnt_q == CW'(BIT_CYCLES - 1));
  assign pre_tick_o = (cnt_q == CW'(BIT_CYCLES - 2));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-deep holding register; frames go out back-to-back.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  uart_tx_if.slave   bus
);

  localparam int unsigned BIT_CYCLES = CLK_FREQ / BAUD_RATE;

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_idx_q;
  logic                 out_data_q;
  logic                 out_done_q;
  logic                 tick, pre_tick;
  logic                 accept, load;

  assign accept = bus.in_en && !hold_full_q;
  // The holding byte moves to the shifter from IDLE, or at the end of STOP with no idle gap.
  assign load   = hold_full_q && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && tick));

  uart_baud_gen #(.BIT_CYCLES(BIT_CYCLES)) u_baud (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (load),
    .tick_o     (tick),
    .pre_tick_o (pre_tick)
  );

  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    if (load)   hold_full_d = 1'b0;
    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
    end else begin
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      out_data_q <= 1'b1;
      out_done_q <= 1'b0;
    end else begin
      // Registered one clock early so the pulse lands in the final stop-bit clock.
      out_done_q <= (state_q == ST_STOP) && pre_tick;
      if (load) begin
        shift_q    <= hold_data_q;
        bit_idx_q  <= '0;
        out_data_q <= 1'b0;
        state_q    <= ST_START;
      end else begin
        case (state_q)
          ST_IDLE: out_data_q <= 1'b1;
          ST_START: begin
            if (tick) begin
              out_data_q <= shift_q[0];
              state_q    <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (tick) begin
              if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                out_data_q <= 1'b1;
                state_q    <= ST_STOP;
              end else begin
                shift_q    <= shift_q >> 1;
                out_data_q <= shift_q[1];
                bit_idx_q  <= bit_idx_q + 3'd1;
              end
            end
          end
          ST_STOP: begin
            if (tick) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready = !hold_full_q;
  assign bus.out_data = out_data_q;
  assign bus.out_done = out_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: timeline reference model, line decoder, directed and random traffic.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int BC    = 20;
  localparam int FRAME = 10 * BC;

  logic clk = 1'b1;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_if u_if();

  uart_tx #(.CLK_FREQ(50_000_000), .BAUD_RATE(2_500_000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_cmp  = 0;
  int n_err  = 0;
  int ecount = 0;
  always @(posedge clk) ecount <= ecount + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, ecount, act, exp);
    end
  endfunction

  // Reference timeline: each accepted byte owns a frame [s, e) of edges.
  typedef struct {
    int         acc;
    int         s;
    int         e;
    logic [7:0] d;
  } frame_t;

  frame_t     fr[$];
  int         last_end = 0;
  bit         armed    = 0;
  int         done_cnt = 0;
  logic [7:0] rx_q[$];
  bit         dbusy    = 0;
  int         dstart   = 0;
  logic [7:0] dbyte;

  always @(negedge clk) begin : mon
    int t, k, off;
    logic el, ed, er;
    frame_t nf;
    frame_t keep[$];
    t = ecount;
    if (armed) begin
      el = 1'b1; ed = 1'b0; er = 1'b1;
      foreach (fr[i]) begin
        if (t >= fr[i].s && t < fr[i].e) begin
          k  = (t - fr[i].s) / BC;
          el = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : fr[i].d[k-1];
        end
        if (t == fr[i].s + FRAME - 1 && t < fr[i].e) ed = 1'b1;
        if (t >= fr[i].acc && t < fr[i].s) er = 1'b0;
      end
      chk("model_line",  u_if.out_data, el);
      chk("model_done",  u_if.out_done, ed);
      chk("model_ready", u_if.in_ready, er);
      if (u_if.out_done === 1'b1) done_cnt++;
      // Independent receiver: sample each bit at its centre.
      if (!dbusy) begin
        if (u_if.out_data === 1'b0) begin
          dbusy  = 1;
          dstart = t;
        end
      end else begin
        off = t - dstart;
        if (off % BC == BC / 2) begin
          k = off / BC;
          if (k == 0 && u_if.out_data !== 1'b0) dbusy = 0;
          else if (k >= 1 && k <= 8) dbyte[k-1] = u_if.out_data;
          else if (k == 9) begin
            chk("rx_stop_bit", u_if.out_data, 1);
            rx_q.push_back(dbyte);
            dbusy = 0;
          end
        end
      end
    end
    if (rst === 1'b1) begin
      keep.delete();
      foreach (fr[i]) begin
        if (fr[i].s < t + 1) begin
          nf = fr[i];
          if (nf.e > t + 1) nf.e = t + 1;
          keep.push_back(nf);
        end
      end
      fr       = keep;
      last_end = 0;
      armed    = 1;
      dbusy    = 0;
    end else if (armed && u_if.in_en === 1'b1 && u_if.in_ready === 1'b1) begin
      nf.acc   = t + 1;
      nf.s     = (t + 2 > last_end) ? t + 2 : last_end;
      nf.e     = nf.s + FRAME;
      nf.d     = u_if.in_data;
      last_end = nf.e;
      fr.push_back(nf);
    end
    while (fr.size() > 0 && fr[0].e < t) void'(fr.pop_front());
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] d, output int acc_edge);
    logic rdy;
    u_if.in_data = d;
    u_if.in_en   = 1'b1;
    acc_edge     = -1;
    for (int i = 0; i < 600; i++) begin
      rdy = u_if.in_ready;
      @(posedge clk);
      #1;
      if (rdy === 1'b1) begin
        acc_edge   = ecount;
        u_if.in_en = 1'b0;
        return;
      end
    end
    u_if.in_en = 1'b0;
    chk("send_ready_timeout", u_if.in_ready, 1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no completion, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int e, e1, e2, s1, s2, d0;
    vec_t vt[4];
    logic [7:0] exp4[4];

    rst          = 1'b1;
    u_if.in_en   = 1'b1;
    u_if.in_data = 8'h5A;

    // Line levels start-bit first: {stop, data[7:0], start}
    vt[0] = '{8'h55, 10'b1010101010};
    vt[1] = '{8'h00, 10'b1000000000};
    vt[2] = '{8'hFF, 10'b1111111110};
    vt[3] = '{8'h3C, 10'b1001111000};

    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("rst_line",  u_if.out_data, 1);
      chk("rst_ready", u_if.in_ready, 1);
      chk("rst_done",  u_if.out_done, 0);
    end
    rst        = 1'b0;
    u_if.in_en = 1'b0;
    step(50);
    chk("post_rst_no_frame", rx_q.size(), 0);
    chk("post_rst_line", u_if.out_data, 1);

    foreach (vt[v]) begin
      step(30);
      d0 = done_cnt;
      rx_q.delete();
      send(vt[v].data, e);
      chk("tbl_ready_after_accept", u_if.in_ready, 0);
      step(1);
      chk("tbl_ready_release", u_if.in_ready, 1);
      step(BC / 2);
      for (int k = 0; k < 10; k++) begin
        chk("tbl_bit_centre", u_if.out_data, vt[v].line[k]);
        if (k < 9) step(BC);
      end
      step(BC / 2 - 1);
      chk("tbl_done_last_clock", u_if.out_done, 1);
      step(1);
      chk("tbl_done_after", u_if.out_done, 0);
      chk("tbl_done_count", done_cnt - d0, 1);
      chk("tbl_rx_byte", (rx_q.size() == 1) ? rx_q[0] : 8'hxx, vt[v].data);
    end

    // Back-to-back frames, then a third byte offered under backpressure.
    step(30);
    rx_q.delete();
    send(8'h55, e1);
    s1 = e1 + 1;
    step(40);
    send(8'hBC, e2);
    chk("b2b_accept_edge", e2, s1 + 40);
    chk("b2b_ready_low", u_if.in_ready, 0);
    step(s1 + FRAME - 1 - ecount);
    chk("b2b_ready_held", u_if.in_ready, 0);
    chk("b2b_stop_level", u_if.out_data, 1);
    step(1);
    chk("b2b_start_no_gap", u_if.out_data, 0);
    chk("b2b_ready_free", u_if.in_ready, 1);
    s2 = ecount;
    send(8'h77, e);
    send(8'hA3, e);
    chk("bp_accept_edge", e, s2 + FRAME + 1);
    step(3 * FRAME);
    exp4 = '{8'h55, 8'hBC, 8'h77, 8'hA3};
    chk("loop_rx_count", rx_q.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("loop_rx_byte", (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp4[i]);

    // Reset during data bit 3 with a byte pending.
    step(30);
    rx_q.delete();
    d0 = done_cnt;
    send(8'hC6, e);
    s1 = e + 1;
    send(8'h3A, e2);
    step(s1 + 4 * BC + 5 - 1 - ecount);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_line",  u_if.out_data, 1);
    chk("mid_rst_ready", u_if.in_ready, 1);
    chk("mid_rst_done",  u_if.out_done, 0);
    step(2 * FRAME + 50);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_no_rx", rx_q.size(), 0);
    send(8'h0F, e);
    step(FRAME + 10);
    chk("post_rst_frame_count", rx_q.size(), 1);
    chk("post_rst_frame_byte", (rx_q.size() > 0) ? rx_q[0] : 8'hxx, 8'h0F);
    chk("post_rst_done_count", done_cnt - d0, 1);

    // Random traffic with occasional resets; the monitor checks every cycle.
    for (int n = 0; n < 30; n++) begin
      step(int'($urandom_range(0, 230)));
      if ($urandom_range(0, 7) == 0) begin
        step(int'($urandom_range(0, 150)));
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end
      send(8'($urandom), e);
    end
    step(3 * FRAME);
    chk("final_line",  u_if.out_data, 1);
    chk("final_ready", u_if.in_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
